// File: rtl/modulo_decodificador_bcd_rolhas_pkg.sv
// Shared types and constants for the serial BCD cork-count decoder.
package rolhas_pkg;
  localparam int              ROLHAS_W       = 7;
  localparam logic [3:0]      BCD_MAX        = 4'd9;
  localparam int              MAX_ROLHAS_DEF = 99;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_UNITS,
    DONE,
    ERR
  } state_t;
endpackage

// File: rtl/modulo_decodificador_bcd_rolhas_mul10.sv
// Combinational tens*10 + units using shift-add; 99 max fits in ROLHAS_W bits.
module bcd_mul10_add
  import rolhas_pkg::*;
(
  input  logic [3:0]          tens,
  input  logic [3:0]          units,
  output logic [ROLHAS_W-1:0] value
);
  logic [ROLHAS_W-1:0] t, u;

  assign t     = {{(ROLHAS_W-4){1'b0}}, tens};
  assign u     = {{(ROLHAS_W-4){1'b0}}, units};
  assign value = (t << 3) + (t << 1) + u;
endmodule

// File: rtl/modulo_decodificador_bcd_rolhas.sv
// Serial two-digit BCD (tens first) to binary cork count decoder.
// Optional range check against MAX_ROLHAS compiled in with DECOD_ROLHAS_LIMIT_EN.
module modulo_decodificador_bcd_rolhas
  import rolhas_pkg::*;
#(
  parameter int MAX_ROLHAS = MAX_ROLHAS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [3:0]          digit_in,
  input  logic                digit_valid,
  input  logic                enter,
  output logic                digit_ready,
  output logic [ROLHAS_W-1:0] value,
  output logic                done,
  output logic                error
);
`ifdef DECOD_ROLHAS_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  state_t              state, nxt_state;
  logic [3:0]          tens;
  logic [ROLHAS_W-1:0] mul, result;
  logic                accept, bad_digit;
  logic                load_tens, complete, to_err;

  bcd_mul10_add u_mul (
    .tens  (tens),
    .units (digit_in),
    .value (mul)
  );

  assign accept    = digit_valid && digit_ready;
  assign bad_digit = digit_in > BCD_MAX;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    load_tens = 1'b0;
    complete  = 1'b0;
    to_err    = 1'b0;
    result    = mul;
    if (clear) begin
      nxt_state = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          if (bad_digit) begin
            nxt_state = ERR;
            to_err    = 1'b1;
          end else begin
            nxt_state = WAIT_UNITS;
            load_tens = 1'b1;
          end
        end
        WAIT_UNITS: if (accept) begin
          if (bad_digit) begin
            nxt_state = ERR;
            to_err    = 1'b1;
          end else begin
            complete  = 1'b1;
          end
        end else if (enter) begin
          // single-digit entry: the stored digit is really the units digit
          complete = 1'b1;
          result   = {{(ROLHAS_W-4){1'b0}}, tens};
        end
        DONE:    nxt_state = IDLE;
        default: nxt_state = ERR;
      endcase
      if (complete) begin
        if (LIMIT_EN && (int'(result) > MAX_ROLHAS)) begin
          complete  = 1'b0;
          to_err    = 1'b1;
          nxt_state = ERR;
        end else begin
          nxt_state = DONE;
        end
      end
    end
  end

  always_comb begin
    digit_ready = ((state == IDLE) || (state == WAIT_UNITS)) && !clear;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tens  <= '0;
      value <= '0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      done <= complete;
      if (clear) begin
        tens  <= '0;
        error <= 1'b0;
      end else begin
        if (load_tens) tens  <= digit_in;
        if (complete)  value <= result;
        if (to_err)    error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_modulo_decodificador_bcd_rolhas.sv
// Directed plus random stimulus against a digit-list reference model.
module tb_modulo_decodificador_bcd_rolhas;
  localparam int TB_MAX = 60;

  logic       clk = 1'b0;
  logic       reset, clear, digit_valid, enter;
  logic [3:0] digit_in;
  logic       digit_ready, done, error;
  logic [6:0] value;

  int vectors = 0;
  int miss    = 0;

  // reference model: list of accepted digits, plus sticky error and completion-gap flag
  int   m_digits[$];
  bit   m_err, m_busy, m_done;
  int   m_val;

  modulo_decodificador_bcd_rolhas #(.MAX_ROLHAS(TB_MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .enter       (enter),
    .digit_ready (digit_ready),
    .value       (value),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic finish_entry(input int res);
    m_digits.delete();
`ifdef DECOD_ROLHAS_LIMIT_EN
    if (res > TB_MAX) begin
      m_err = 1'b1;
      return;
    end
`endif
    m_val  = res;
    m_done = 1'b1;
    m_busy = 1'b1;
  endtask

  task automatic model_step(input bit c, input bit v, input int d, input bit e);
    m_done = 1'b0;
    if (c) begin
      m_digits.delete();
      m_err  = 1'b0;
      m_busy = 1'b0;
    end else if (m_err) begin
    end else if (m_busy) begin
      m_busy = 1'b0;
    end else if (v) begin
      if (d > 9) begin
        m_err = 1'b1;
        m_digits.delete();
      end else begin
        m_digits.push_back(d);
        if (m_digits.size() == 2) finish_entry(m_digits[0] * 10 + m_digits[1]);
      end
    end else if (e && m_digits.size() == 1) begin
      finish_entry(m_digits[0]);
    end
  endtask

  task automatic cyc(input bit c, input bit v, input int d, input bit e);
    clear = c; digit_valid = v; digit_in = 4'(d); enter = e;
    #1;
    chk("digit_ready", {7'd0, digit_ready}, {7'd0, (!m_err && !m_busy && !c)});
    @(posedge clk);
    model_step(c, v, d, e);
    #1;
    vectors++;
    chk("value", {1'b0, value}, 8'(m_val));
    chk("done",  {7'd0, done},  {7'd0, m_done});
    chk("error", {7'd0, error}, {7'd0, m_err});
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; digit_valid = 1'b0; digit_in = '0; enter = 1'b0;
    m_err = 0; m_busy = 0; m_done = 0; m_val = 0;
    @(posedge clk); @(posedge clk); #1;
    vectors++;
    chk("rst_value", {1'b0, value}, 8'd0);
    chk("rst_done",  {7'd0, done},  8'd0);
    chk("rst_error", {7'd0, error}, 8'd0);
    chk("rst_ready", {7'd0, digit_ready}, 8'd1);
    reset = 1'b0;

    cyc(0, 1, 4, 0); cyc(0, 1, 7, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 8, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 3, 0); cyc(0, 1, 12, 0); cyc(0, 1, 5, 0); cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 5, 0); cyc(1, 1, 6, 0); cyc(0, 1, 1, 0); cyc(0, 1, 2, 1);
    cyc(0, 1, 9, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); cyc(0, 1, 7, 0); cyc(0, 1, 2, 0); cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0); cyc(0, 1, 9, 0); cyc(0, 1, 9, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 15, 0); cyc(0, 1, 10, 0); cyc(1, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      bit c, v, e;
      int d;
      c = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 1) == 1);
      e = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      cyc(c, v, d, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule

// File: doc/modulo_decodificador_bcd_rolhas.md
# modulo_decodificador_bcd_rolhas

Sequential BCD-to-binary decoder for the cork-count path. It accepts an operator-entered decimal cork quantity as up to two serial BCD digits, tens first, from the keypad/display side. It assembles them into a 7-bit binary count for the cork unit controller. This is the inverse of the binary-to-BCD unit-digit encoder on the display path.

## Interface
- MAX_ROLHAS, default 99: highest legal cork count. Only used when the range-check feature is compiled in.
- clk  in  1: system clock, rising edge.
- reset  in  1: synchronous, active-high reset.
- clear  in  1: aborts the entry in progress, returns to IDLE and clears error.
- digit_in  in  4: BCD digit. Sampled only when digit_valid=1 and digit_ready=1.
- digit_valid  in  1: digit strobe, one cycle per digit.
- enter  in  1: finishes a single-digit entry early.
- digit_ready  out  1: block can accept a digit this cycle.
- value  out  7: last completed binary cork count. Held until the next completion.
- done  out  1: one-cycle pulse when value updates.
- error  out  1: sticky error flag.

## Operation
- States: IDLE, WAIT_UNITS, DONE, ERR. The state encoding is internal.
- IDLE:
  - digit accepted with digit_in ≤ 9: store it in the tens register, go to WAIT_UNITS.
  - digit_in > 9: go to ERR.
  - enter in IDLE: ignored.
- WAIT_UNITS:
  - digit accepted with digit_in ≤ 9: value ← tens·10 + digit, done=1, go to DONE.
  - digit_in > 9: go to ERR.
  - enter with no digit strobe: treat the stored tens digit as the units digit. value ← tens register, done=1, go to DONE.
  - digit_valid and enter in the same cycle: the digit wins and enter is ignored.
- Multiply by 10 is computed as (t<<3)+(t<<1)+u in 7 bits. The maximum is 99, so the result never overflows.
- DONE: digit_ready=0. Go to IDLE on the next edge unconditionally.
- ERR: error=1, digit_ready=0. Stay in ERR until clear or reset. value is unchanged.
- digit_ready=1 only in IDLE and WAIT_UNITS, and never while clear=1.
- Priority at every edge: reset > clear > digit_valid > enter.
- clear mid-entry: the tens register is discarded, value and done are unaffected, state goes to IDLE.

## Timing
- Reset values: state=IDLE, value=0, done=0, error=0, digit_ready=1 (after the reset edge), tens register=0.
- Latency: the units digit is accepted at edge N. value and done are visible after edge N. done drops after edge N+1.
- The same applies to enter accepted at edge N.
- Minimum spacing between entries: after a completion at edge N, the next tens digit can be accepted at edge N+2 (DONE occupies one cycle).
- A digit_valid pulse while digit_ready=0 is dropped silently, with no state change.
- All outputs are registered. There are no combinational paths from inputs to value, done or error.
- digit_ready is combinational from state and clear.

## Configuration
- DECOD_ROLHAS_LIMIT_EN:
  - Defined: a completed value greater than MAX_ROLHAS does not update value and does not pulse done. The state goes to ERR and error=1 after the same edge.
  - Undefined: any 0–99 result completes normally, and MAX_ROLHAS is unused.

## Structure
- Shared package (rolhas_pkg):
  - the state enum;
  - BCD_MAX = 9;
  - the cork-count width (7);
  - the default MAX_ROLHAS.
- One sub-module: bcd_mul10_add, combinational, tens[3:0] and units[3:0] in, value[6:0] out.
- The FSM, registers and the optional range check stay in the top module.

## Test plan
- Reset, then digits 4 then 7 → done pulses once after the second digit, value=47, error=0, digit_ready back to 1 two cycles later.
- Digit 8, then enter with no second digit → value=8, done one cycle.
- Digit 3, then digit_valid with 0xC → error=1 and stays set. value keeps its previous value. clear → IDLE, error=0.
- Digit 5, then clear, then digits 1 and 2 → value=12. The discarded 5 has no effect.
- DONE state with a digit_valid strobe (9) → dropped. The next entry of 0 then 0 gives value=0.
- With DECOD_ROLHAS_LIMIT_EN and MAX_ROLHAS=60, digits 7 and 2 → no done, value unchanged, error=1. Without the macro the same input gives value=72.
